// File: rtl/fifo_axis_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_axis_pkg
// Description : Shared definitions for the FIFO-to-AXI4-Stream read engine.
//               Holds the output buffer depth, a ceiling-log2 helper and the
//               stream beat record.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_axis_pkg;

    // Number of words the output buffer can hold. Two entries cover the
    // FIFO's one-cycle registered read latency at one beat per clock.
    localparam int BUF_DEPTH = 2;

    // Data width of the default build.
    localparam int DEFAULT_DSIZE = 32;

    // Ceiling log2. The result is 0 for inputs of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // One stream beat at the default data width.
    typedef struct packed {
        logic [DEFAULT_DSIZE-1:0] tdata;
        logic                     tlast;
    } fifo_axis_beat_t;

endpackage : fifo_axis_pkg
`default_nettype wire

// File: rtl/fifo_axis_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_axis_reader_if
// Description : AXI4-Stream bundle (tdata/tvalid/tready/tlast) with master
//               and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_axis_reader_if #(
    parameter int DSIZE = 32
);
    logic [DSIZE-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface : fifo_axis_reader_if
`default_nettype wire

// File: rtl/axis_skid_buf2.sv
`default_nettype none
// ============================================================================
// Module      : axis_skid_buf2
// Description : Two-entry, order-preserving output buffer. Entry 0 is the
//               head presented downstream. A write and a pop in the same
//               cycle shift the next word into the head without a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_buf2
    import fifo_axis_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic                              clk,
    input  wire logic                              rst_n,
    input  wire logic                              i_wr_en,
    input  wire logic [WIDTH-1:0]                  i_wr_data,
    input  wire logic                              i_pop,
    output logic      [WIDTH-1:0]                  o_head,
    output logic                                   o_valid,
    output logic      [clog2(BUF_DEPTH+1)-1:0]     o_cnt
);

    localparam int c_cnt_w = clog2(BUF_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_empty = '0;
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(BUF_DEPTH);

    logic [WIDTH-1:0]   r_e0;
    logic [WIDTH-1:0]   r_e1;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_valid;

    // Ordered write/pop update; head and valid are registered so they only
    // move on a pop or when an empty buffer receives its first word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_cnt   <= c_empty;
            r_valid <= 1'b0;
        end else begin
            unique case ({i_wr_en, i_pop})
                2'b10: begin
                    if (r_cnt == c_empty) begin
                        r_e0 <= i_wr_data;
                    end else begin
                        r_e1 <= i_wr_data;
                    end
                    r_cnt   <= r_cnt + c_one;
                    r_valid <= 1'b1;
                end
                2'b01: begin
                    r_e0    <= r_e1;
                    r_cnt   <= r_cnt - c_one;
                    r_valid <= (r_cnt != c_one);
                end
                2'b11: begin
                    if (r_cnt == c_full) begin
                        r_e0 <= r_e1;
                        r_e1 <= i_wr_data;
                    end else begin
                        r_e0 <= i_wr_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_head  = r_e0;
    assign o_valid = r_valid;
    assign o_cnt   = r_cnt;

    // A write into a full buffer without a matching pop would lose a word.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(i_wr_en && !i_pop && (r_cnt == c_full)));

    // Popping an empty buffer would emit a spurious beat.
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(i_pop && (r_cnt == c_empty)));

endmodule : axis_skid_buf2
`default_nettype wire

// File: rtl/fifo_axis_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_axis_reader
// Description : Drains a synchronous FIFO (registered rdata) and presents
//               the words as an AXI4-Stream master at one beat per clock.
//               Owns the read strobe, in-flight tracking, the packet
//               counter and the accepted-beat counter.
//               Optional macro: FIFO_AXIS_READER_TLAST_EN enables tlast
//               generation every PKT_LEN beats; otherwise tlast is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_axis_reader
    import fifo_axis_pkg::*;
#(
    parameter int DSIZE   = 32,
    parameter int PKT_LEN = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    output logic                  rinc,
    input  wire logic             rempty,
    input  wire logic [DSIZE-1:0] rdata,
    fifo_axis_reader_if.master    m_axis,
    output logic      [31:0]      beat_cnt
);

    localparam int c_buf_cnt_w = clog2(BUF_DEPTH + 1);

    logic                   r_inflight;
    logic [31:0]            r_beat_cnt;
    logic [DSIZE-1:0]       w_head;
    logic                   w_valid;
    logic [c_buf_cnt_w-1:0] w_buf_cnt;
    logic                   w_pop;
    logic [2:0]             w_fill;

    // A beat leaves when the head is valid and the consumer takes it.
    assign w_pop = w_valid && m_axis.tready;

    // Occupancy after this cycle's write and pop: words held plus the word
    // arriving from the FIFO, minus the one leaving.
    assign w_fill = 3'(w_buf_cnt) + {2'b00, r_inflight} - {2'b00, w_pop};

    // Only request a word when there is guaranteed room for it next cycle.
    // Never strobe an empty FIFO: it would update rdata anyway.
    assign rinc = !rempty && (w_fill <= 3'd1);

    // The FIFO presents the requested word one cycle after the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= rinc;
        end
    end

    axis_skid_buf2 #(
        .WIDTH (DSIZE)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (r_inflight),
        .i_wr_data (rdata),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_valid   (w_valid),
        .o_cnt     (w_buf_cnt)
    );

    assign m_axis.tdata  = w_head;
    assign m_axis.tvalid = w_valid;

    // Free-running count of accepted beats, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
        end
    end

    assign beat_cnt = r_beat_cnt;

`ifdef FIFO_AXIS_READER_TLAST_EN
    localparam int                 c_pkt_cnt_w = clog2(PKT_LEN) + 1;
    localparam logic [c_pkt_cnt_w-1:0] c_last_idx = c_pkt_cnt_w'(PKT_LEN - 1);

    logic [c_pkt_cnt_w-1:0] r_pkt_cnt;

    // Position of the head beat within its packet; it only moves on a pop,
    // so tlast stays aligned with tdata under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_cnt <= '0;
        end else if (w_pop) begin
            if (r_pkt_cnt == c_last_idx) begin
                r_pkt_cnt <= '0;
            end else begin
                r_pkt_cnt <= r_pkt_cnt + c_pkt_cnt_w'(1);
            end
        end
    end

    assign m_axis.tlast = w_valid && (r_pkt_cnt == c_last_idx);
`else
    assign m_axis.tlast = 1'b0;
`endif

    // Buffer occupancy must never exceed its depth.
    a_fill_bound : assert property (@(posedge clk) disable iff (!rst_n)
        w_fill <= 3'(BUF_DEPTH));

    // The read strobe must never fire against an empty FIFO.
    a_no_empty_read : assert property (@(posedge clk) disable iff (!rst_n)
        !(rinc && rempty));

endmodule : fifo_axis_reader
`default_nettype wire
